// File: rtl/tdoa_result_reader.sv
// Reads one TDoA trigger triple, validates the pairwise deltas and holds
// the result for the CPU; re-arms the TDoA core after every outcome.
module tdoa_result_reader #(
  parameter int unsigned REARM_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 48000,
  parameter int unsigned MAX_DELTA      = 64
) (
  input  logic               pcm_clk,
  input  logic               reset,
  input  logic [31:0]        trigger_time_1,
  input  logic [31:0]        trigger_time_2,
  input  logic [31:0]        trigger_time_3,
  input  logic               result_ack,
  output logic               rearm_out,
  output logic signed [31:0] delta_12,
  output logic signed [31:0] delta_13,
  output logic [1:0]         first_mic,
  output logic               result_valid,
  output logic [15:0]        rejected_count,
  output logic [15:0]        timeout_count
);

  typedef enum logic [1:0] {
    REARM,
    ARMED,
    CHECK,
    PRESENT
  } state_t;

  localparam int unsigned RW =
    REARM_CYCLES > 1 ? $clog2(REARM_CYCLES + 1) : 1;
  localparam int unsigned TW =
    TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLAST =
    TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic signed [32:0] MAXD = 33'(MAX_DELTA);

  state_t            state;
  logic [RW-1:0]     rearm_cnt;
  logic [TW-1:0]     arm_cnt;
  logic [31:0]       t1_q, t2_q, t3_q;
  logic signed [31:0] d12, d13;
  logic signed [32:0] d12_x, d13_x;
  logic              out_of_range;
  logic [1:0]        fm;
  logic              all_reported;
  logic              timed_out;

  assign all_reported = (trigger_time_1 != '0) &&
                        (trigger_time_2 != '0) &&
                        (trigger_time_3 != '0);
  assign timed_out = (TIMEOUT_CYCLES != 0) &&
                     (arm_cnt == TW'(TLAST));

  // Modulo subtraction keeps deltas correct across sample-counter wrap.
  assign d12   = $signed(t2_q - t1_q);
  assign d13   = $signed(t3_q - t1_q);
  assign d12_x = {d12[31], d12};
  assign d13_x = {d13[31], d13};

  assign out_of_range = (d12_x > MAXD) || (d12_x < -MAXD) ||
                        (d13_x > MAXD) || (d13_x < -MAXD);

  always_comb begin
    fm = 2'd3;
    if (!d12[31] && !d13[31])
      fm = 2'd1;
    else if (d12 <= d13)
      fm = 2'd2;
  end

  always_ff @(posedge pcm_clk) begin
    if (reset) begin
      state          <= REARM;
      rearm_cnt      <= RW'(REARM_CYCLES);
      rearm_out      <= 1'b1;
      arm_cnt        <= '0;
      t1_q           <= '0;
      t2_q           <= '0;
      t3_q           <= '0;
      delta_12       <= '0;
      delta_13       <= '0;
      first_mic      <= 2'd1;
      result_valid   <= 1'b0;
      rejected_count <= '0;
      timeout_count  <= '0;
    end else begin
      unique case (state)
        REARM: begin
          if (rearm_cnt <= RW'(1)) begin
            state     <= ARMED;
            rearm_out <= 1'b0;
            arm_cnt   <= '0;
          end else begin
            rearm_cnt <= rearm_cnt - RW'(1);
          end
        end
        ARMED: begin
          if (all_reported) begin
            t1_q  <= trigger_time_1;
            t2_q  <= trigger_time_2;
            t3_q  <= trigger_time_3;
            state <= CHECK;
          end else if (timed_out) begin
            state     <= REARM;
            rearm_cnt <= RW'(REARM_CYCLES);
            rearm_out <= 1'b1;
            if (timeout_count != 16'hFFFF)
              timeout_count <= timeout_count + 16'd1;
          end else begin
            arm_cnt <= arm_cnt + TW'(1);
          end
        end
        CHECK: begin
          if (out_of_range) begin
            state     <= REARM;
            rearm_cnt <= RW'(REARM_CYCLES);
            rearm_out <= 1'b1;
            if (rejected_count != 16'hFFFF)
              rejected_count <= rejected_count + 16'd1;
          end else begin
            delta_12     <= d12;
            delta_13     <= d13;
            first_mic    <= fm;
            result_valid <= 1'b1;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= REARM;
            rearm_cnt    <= RW'(REARM_CYCLES);
            rearm_out    <= 1'b1;
          end
        end
        default: state <= REARM;
      endcase
    end
  end

endmodule

// File: tb/tb_tdoa_result_reader.sv
// Directed bench for tdoa_result_reader: phase-level model checked every
// cycle, plus literal expectations for each directed vector.
module tb_tdoa_result_reader;

  localparam int R  = 4;
  localparam int TO = 10;
  localparam int MD = 64;

  logic               pcm_clk = 1'b0;
  logic               reset = 1'b1;
  logic [31:0]        t1 = '0, t2 = '0, t3 = '0;
  logic               result_ack = 1'b0;
  logic               rearm_out;
  logic signed [31:0] delta_12, delta_13;
  logic [1:0]         first_mic;
  logic               result_valid;
  logic [15:0]        rejected_count, timeout_count;

  int checks = 0;
  int failures = 0;

  tdoa_result_reader #(
    .REARM_CYCLES(R),
    .TIMEOUT_CYCLES(TO),
    .MAX_DELTA(MD)
  ) dut (
    .pcm_clk(pcm_clk),
    .reset(reset),
    .trigger_time_1(t1),
    .trigger_time_2(t2),
    .trigger_time_3(t3),
    .result_ack(result_ack),
    .rearm_out(rearm_out),
    .delta_12(delta_12),
    .delta_13(delta_13),
    .first_mic(first_mic),
    .result_valid(result_valid),
    .rejected_count(rejected_count),
    .timeout_count(timeout_count)
  );

  always #5 pcm_clk = ~pcm_clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: phase 0 re-arming, 1 waiting, 2 validating, 3 showing result.
  int          ph;
  int          left;
  int          age;
  bit          m_live = 0;
  logic [31:0] c1, c2, c3;
  int          e_d12, e_d13, e_fm, e_rej, e_to;

  always @(posedge pcm_clk) begin
    if (reset) begin
      ph = 0; left = R; age = 0;
      e_d12 = 0; e_d13 = 0; e_fm = 1;
      e_rej = 0; e_to = 0; m_live = 1;
    end else if (m_live) begin
      case (ph)
        0: begin
          left--;
          if (left <= 0) begin ph = 1; age = 0; end
        end
        1: begin
          if (t1 != 0 && t2 != 0 && t3 != 0) begin
            c1 = t1; c2 = t2; c3 = t3; ph = 2;
          end else begin
            age++;
            if (age == TO) begin
              ph = 0; left = R;
              if (e_to < 65535) e_to++;
            end
          end
        end
        2: begin
          logic [31:0] x, y;
          longint a, b;
          int p, q;
          x = c2 - c1; y = c3 - c1;
          p = $signed(x); q = $signed(y);
          a = (p < 0) ? -longint'(p) : longint'(p);
          b = (q < 0) ? -longint'(q) : longint'(q);
          if (a > MD || b > MD) begin
            ph = 0; left = R;
            if (e_rej < 65535) e_rej++;
          end else begin
            e_d12 = p; e_d13 = q; ph = 3;
            if (p >= 0 && q >= 0) e_fm = 1;
            else if (p <= q) e_fm = 2;
            else e_fm = 3;
          end
        end
        default: begin
          if (result_ack) begin ph = 0; left = R; end
        end
      endcase
    end
  end

  always @(negedge pcm_clk) begin
    if (m_live) begin
      chk("m_rearm_out", rearm_out, (ph == 0));
      chk("m_result_valid", result_valid, (ph == 3));
      chk("m_delta_12", delta_12, e_d12);
      chk("m_delta_13", delta_13, e_d13);
      chk("m_first_mic", first_mic, e_fm);
      chk("m_rejected_count", rejected_count, e_rej);
      chk("m_timeout_count", timeout_count, e_to);
    end
  end

  task automatic count_rearm(input string nm);
    int n = 0;
    while (rearm_out === 1'b1 && n < 50) begin
      n++;
      @(negedge pcm_clk);
    end
    chk(nm, n, R);
  endtask

  typedef struct {
    logic [31:0] a, b, c;
    bit          ok;
    int          d12, d13, fm, rej, hold;
  } vec_t;

  vec_t v[9];

  initial begin
    #200000;
    $display("FAIL watchdog no finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{32'd1000, 32'd1003, 32'd998, 1'b1, 3, -2, 3, 0, 100};
    v[1] = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 1'b1, 3, 0, 1, 0, 2};
    v[2] = '{32'd1005, 32'd1000, 32'd1002, 1'b1, -5, -3, 2, 0, 2};
    v[3] = '{32'd1000, 32'd1064, 32'd936, 1'b1, 64, -64, 3, 0, 2};
    v[4] = '{32'd500, 32'd600, 32'd500, 1'b0, 0, 0, 0, 1, 0};
    v[5] = '{32'd1000, 32'd1065, 32'd1000, 1'b0, 0, 0, 0, 2, 0};
    v[6] = '{32'd1000, 32'd1000, 32'd900, 1'b0, 0, 0, 0, 3, 0};
    v[7] = '{32'd1000, 32'd990, 32'd990, 1'b1, -10, -10, 2, 3, 2};
    v[8] = '{32'd7, 32'd7, 32'd7, 1'b1, 0, 0, 1, 3, 2};

    repeat (3) @(negedge pcm_clk);
    chk("rst_rearm_out", rearm_out, 1);
    chk("rst_valid", result_valid, 0);
    chk("rst_rejected", rejected_count, 0);
    chk("rst_timeout", timeout_count, 0);
    chk("rst_first_mic", first_mic, 1);
    chk("rst_delta_12", delta_12, 0);
    chk("rst_delta_13", delta_13, 0);

    reset = 1'b0;
    count_rearm("rearm_len_after_reset");

    foreach (v[i]) begin
      t1 = v[i].a; t2 = v[i].b; t3 = v[i].c;
      @(negedge pcm_clk);
      t1 = $urandom; t2 = $urandom; t3 = $urandom;
      chk("valid_at_n1", result_valid, 0);
      @(negedge pcm_clk);
      if (v[i].ok) begin
        chk("valid_at_n2", result_valid, 1);
        chk("vec_delta_12", delta_12, v[i].d12);
        chk("vec_delta_13", delta_13, v[i].d13);
        chk("vec_first_mic", first_mic, v[i].fm);
        repeat (v[i].hold) begin
          t1 = $urandom; t2 = $urandom; t3 = $urandom;
          result_ack = 1'b0;
          @(negedge pcm_clk);
        end
        chk("held_valid", result_valid, 1);
        chk("held_delta_12", delta_12, v[i].d12);
        chk("held_delta_13", delta_13, v[i].d13);
        result_ack = 1'b1;
        t1 = '0; t2 = '0; t3 = '0;
        @(negedge pcm_clk);
        result_ack = 1'b0;
        chk("valid_after_ack", result_valid, 0);
        chk("rearm_after_ack", rearm_out, 1);
      end else begin
        t1 = '0; t2 = '0; t3 = '0;
        chk("reject_valid", result_valid, 0);
        chk("reject_rearm", rearm_out, 1);
        chk("reject_count", rejected_count, v[i].rej);
      end
      count_rearm("rearm_len");
    end

    begin
      int n = 0;
      result_ack = 1'b1;
      while (rearm_out === 1'b0 && n < 40) begin
        n++;
        @(negedge pcm_clk);
      end
      result_ack = 1'b0;
      chk("armed_cycles_to_timeout", n, TO);
      chk("timeout_count", timeout_count, 1);
      count_rearm("rearm_len_after_timeout");
    end

    t1 = 32'd1000; t2 = 32'd1003; t3 = 32'd998;
    @(negedge pcm_clk);
    @(negedge pcm_clk);
    chk("present_before_reset", result_valid, 1);
    reset = 1'b1;
    @(negedge pcm_clk);
    chk("reset_in_present_valid", result_valid, 0);
    chk("reset_in_present_rearm", rearm_out, 1);
    chk("reset_in_present_rej", rejected_count, 0);
    chk("reset_in_present_to", timeout_count, 0);
    chk("reset_in_present_d12", delta_12, 0);
    reset = 1'b0;
    t1 = '0; t2 = '0; t3 = '0;
    count_rearm("rearm_len_after_reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
